// File: rtl/lifo_pkg.sv
// Shared constants, count-width helper and the per-cycle operation code for param_lifo.
package lifo_pkg;

    localparam int unsigned LIFO_WIDTH = 8;
    localparam int unsigned LIFO_DEPTH = 8;

    // Occupancy has to represent 0..depth inclusive, so one bit more than the address.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_PUSH_EMPTY,
        OP_OVERFLOW,
        OP_UNDERFLOW
    } op_e;

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module lifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo.sv
// Parameterised LIFO stack: pointer, flags and registered pop output around a lifo_mem array.
module param_lifo
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH    = LIFO_WIDTH,
    parameter int unsigned DEPTH    = LIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wn,
    input  logic                          rn,
    input  logic [WIDTH-1:0]              datain,
    input  logic                          err_clr,
    output logic [WIDTH-1:0]              dataout,
    output logic                          dout_valid,
    output logic [WIDTH-1:0]              top,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    op_e              op;
    logic             mem_we;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] rd_data;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (32'(count) >= AF_LEVEL);

    always_comb begin
        op = OP_NONE;
        unique case ({wn, rn})
            2'b10:   op = full  ? OP_OVERFLOW  : OP_PUSH;
            2'b01:   op = empty ? OP_UNDERFLOW : OP_POP;
            2'b11:   op = empty ? OP_PUSH_EMPTY : OP_REPLACE;
            default: op = OP_NONE;
        endcase
    end

    // Replace-top overwrites the current top slot; plain pushes land one above it.
    assign top_addr = AW'(count - CW'(1));
    assign wr_addr  = (op == OP_REPLACE) ? top_addr : AW'(count);
    assign mem_we   = (op == OP_PUSH) || (op == OP_PUSH_EMPTY) || (op == OP_REPLACE);

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (datain),
        .raddr (top_addr),
        .rdata (rd_data)
    );

    assign top = empty ? '0 : rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            // Clear first so an error raised in the same cycle wins.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            unique case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP: begin
                    count      <= count - CW'(1);
                    dataout    <= rd_data;
                    dout_valid <= 1'b1;
                end
                OP_REPLACE: begin
                    dataout    <= rd_data;
                    dout_valid <= 1'b1;
                end
                OP_PUSH_EMPTY: begin
                    count     <= count + CW'(1);
                    underflow <= 1'b1;
                end
                OP_OVERFLOW:  overflow  <= 1'b1;
                OP_UNDERFLOW: underflow <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/param_lifo.md
PARAM_LIFO -- requirements
Module: param_lifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 8: number of stack entries, a power of two of at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full asserts when count >= AF_LEVEL.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port wn, input, 1: push request.
REQ-007 Port rn, input, 1: pop request.
REQ-008 Port datain, input, WIDTH: word to push.
REQ-009 Port err_clr, input, 1: clears the sticky error flags.
REQ-010 Port dataout, output, WIDTH: registered popped word.
REQ-011 Port dout_valid, output, 1: one-cycle pulse marking a new dataout.
REQ-012 Port top, output, WIDTH: combinational peek of the top entry, or 0 when empty.
REQ-013 Port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-014 Ports full, empty, almost_full, output, 1 each: occupancy flags, combinational from count.
REQ-015 Ports overflow, underflow, output, 1 each: sticky error flags.

Function
REQ-016 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0).
REQ-017 Push only (wn=1, rn=0, not full): mem[count] <= datain and count increments by 1.
REQ-018 Pop only (rn=1, wn=0, not empty): dataout <= mem[count-1], count decrements by 1, and dout_valid=1 on the next cycle.
REQ-019 Push and pop together, not empty (full included): replace-top; dataout <= old top, mem[count-1] <= datain, count unchanged, dout_valid=1, no error.
REQ-020 Push and pop together while empty: the push is performed, the pop is ignored, and underflow is set.
REQ-021 Push only while full: state is unchanged and overflow is set.
REQ-022 Pop only while empty: state is unchanged, dout_valid stays 0, and underflow is set.
REQ-023 dataout SHALL hold its value when no pop occurs; dout_valid SHALL be 0 in every cycle that follows a cycle without an accepted pop.
REQ-024 Pop latency SHALL be 1 cycle; top SHALL reflect a push in the cycle after that push.
REQ-025 overflow and underflow SHALL stay set until err_clr=1 or reset; when err_clr and a new error occur in the same cycle, the flag SHALL be set.
REQ-026 count SHALL never wrap: it is bounded to 0..DEPTH under all request combinations.

Reset
REQ-027 On reset: count=0, dataout=0, dout_valid=0, overflow=0, underflow=0; reset SHALL take priority over wn, rn and err_clr.
REQ-028 Memory contents SHALL NOT be reset; top SHALL still read 0 after reset because the stack is empty.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries within one cycle.

Structure
REQ-030 Package lifo_pkg SHALL hold the default WIDTH/DEPTH constants and a function for the count width.
REQ-031 Storage SHALL be a sub-module lifo_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port; the pointer and flag logic stays in param_lifo.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=7)
REQ-032 Push 0x11..0x88 -> count=8, full=1, almost_full=1 after 7 pushes; a 9th push of 0x99 -> overflow=1, top=0x88.
REQ-033 Pop 8 times from the full stack -> dataout sequence 0x88..0x11, each with dout_valid=1; then empty=1 and top=0.
REQ-034 Stack holding 0x11,0x22, push 0x33 with pop in the same cycle -> dataout=0x22, count=2, top=0x33.
REQ-035 Empty stack, pop -> underflow=1, dout_valid=0; err_clr=1 -> underflow=0 on the next cycle.
REQ-036 Empty stack, push 0x5A with pop in the same cycle -> count=1, top=0x5A, underflow=1.
REQ-037 Reset asserted with count=5 -> next cycle count=0, empty=1, dataout=0, error flags 0.
